// File: rtl/load_store_unit_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
// Big-endian lanes: byte offset 0 sits in bits 31:24.
package load_store_unit_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } lsu_state_e;

    localparam logic [4:0] LANE0_SHIFT = 5'd24;
    localparam logic [4:0] LANE1_SHIFT = 5'd16;
    localparam logic [4:0] LANE2_SHIFT = 5'd8;
    localparam logic [4:0] LANE3_SHIFT = 5'd0;

    // Right-shift that brings the addressed field down to bit 0.
    function automatic logic [4:0] lane_shift(input lsu_size_e size, input logic [1:0] offset);
        logic [4:0] shift;
        shift = LANE3_SHIFT;
        case (size)
            SIZE_BYTE: begin
                case (offset)
                    2'd0:    shift = LANE0_SHIFT;
                    2'd1:    shift = LANE1_SHIFT;
                    2'd2:    shift = LANE2_SHIFT;
                    default: shift = LANE3_SHIFT;
                endcase
            end
            SIZE_HALF: shift = offset[1] ? LANE3_SHIFT : LANE1_SHIFT;
            default:   shift = LANE3_SHIFT;
        endcase
        return shift;
    endfunction

    function automatic logic misaligned(input lsu_size_e size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane extract/extend for loads and lane merge for stores.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]        offset_i,
    input  lsu_size_e         size_i,
    input  logic              signed_i,
    input  logic [WORD_W-1:0] mem_word_i,
    input  logic [WORD_W-1:0] store_data_i,
    output logic [WORD_W-1:0] load_data_c_o,
    output logic [WORD_W-1:0] merged_c_o
);

    logic [4:0]        shift;
    logic [15:0]       lane;
    logic [WORD_W-1:0] mask;

    always_comb begin
        shift = lane_shift(size_i, offset_i);
        lane  = 16'(mem_word_i >> shift);
        case (size_i)
            SIZE_BYTE: mask = 32'h0000_00FF;
            SIZE_HALF: mask = 32'h0000_FFFF;
            default:   mask = 32'hFFFF_FFFF;
        endcase
        case (size_i)
            SIZE_BYTE: load_data_c_o = {{24{signed_i & lane[7]}}, lane[7:0]};
            SIZE_HALF: load_data_c_o = {{16{signed_i & lane[15]}}, lane[15:0]};
            default:   load_data_c_o = mem_word_i;
        endcase
        // Word stores have an all-ones mask and zero shift, so they pass store data through.
        merged_c_o = (mem_word_i & ~(mask << shift)) | ((store_data_i & mask) << shift);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, RMW for sub-word stores, registered memory outputs.
// Memory outputs are computed from the next state so they line up with the state they belong to.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS = 32
) (
    input  logic                     LSU_CLOCK_50,
    input  logic                     LSU_RESET_InHigh,
    input  logic                     LSU_Req_In,
    input  logic                     LSU_Store_In,
    input  logic [1:0]               LSU_Size_In,
    input  logic                     LSU_Signed_In,
    input  logic [DATAWIDTH_BUS-1:0] LSU_Address_In,
    input  logic [DATAWIDTH_BUS-1:0] LSU_StoreData_In,
    output logic                     LSU_Busy_Out,
    output logic                     LSU_Done_Out,
    output logic                     LSU_Error_Out,
    output logic [DATAWIDTH_BUS-1:0] LSU_LoadData_Out,
    output logic [DATAWIDTH_BUS-1:0] LSU_MemAddress_Out,
    output logic [DATAWIDTH_BUS-1:0] LSU_MemData_Out,
    output logic                     LSU_MemRD_Out,
    output logic                     LSU_MemWR_Out,
    input  logic [DATAWIDTH_BUS-1:0] LSU_MemData_In
);

    lsu_state_e               state_q, state_d;
    logic                     store_q, signed_q;
    lsu_size_e                size_q;
    logic [DATAWIDTH_BUS-1:0] addr_q, sdata_q;

    logic                     busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                     rd_q, rd_d, wr_q, wr_d;
    logic [DATAWIDTH_BUS-1:0] ldata_q, ldata_d, maddr_q, maddr_d, mdata_q, mdata_d;

    logic                     idle;
    logic                     cur_store, cur_signed;
    lsu_size_e                cur_size;
    logic [DATAWIDTH_BUS-1:0] cur_addr, cur_sdata;
    logic [DATAWIDTH_BUS-1:0] load_data_c, merged_c;

    // In IDLE the request is still on the inputs; afterwards it lives in the latches.
    always_comb begin
        idle       = (state_q == ST_IDLE);
        cur_store  = idle ? LSU_Store_In : store_q;
        cur_signed = idle ? LSU_Signed_In : signed_q;
        cur_size   = idle ? lsu_size_e'(LSU_Size_In) : size_q;
        cur_addr   = idle ? LSU_Address_In : addr_q;
        cur_sdata  = idle ? LSU_StoreData_In : sdata_q;
    end

    lsu_lane_align u_lane_align (
        .offset_i      (cur_addr[1:0]),
        .size_i        (cur_size),
        .signed_i      (cur_signed),
        .mem_word_i    (LSU_MemData_In),
        .store_data_i  (cur_sdata),
        .load_data_c_o (load_data_c),
        .merged_c_o    (merged_c)
    );

    always_ff @(posedge LSU_CLOCK_50) begin
        if (LSU_RESET_InHigh) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SIZE_BYTE;
            addr_q   <= '0;
            sdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (idle && LSU_Req_In) begin
                store_q  <= LSU_Store_In;
                signed_q <= LSU_Signed_In;
                size_q   <= lsu_size_e'(LSU_Size_In);
                addr_q   <= LSU_Address_In;
                sdata_q  <= LSU_StoreData_In;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (LSU_Req_In) begin
                    if (misaligned(cur_size, cur_addr[1:0]))       state_d = ST_ERR;
                    else if (cur_store && cur_size == SIZE_WORD)   state_d = ST_WRITE;
                    else                                           state_d = ST_READ;
                end
            end
            ST_READ:  state_d = store_q ? ST_WRITE : ST_DONE;
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE) || (state_d == ST_ERR);
        err_d   = (state_d == ST_ERR);
        rd_d    = (state_d == ST_READ);
        wr_d    = (state_d == ST_WRITE);
        maddr_d = (rd_d || wr_d) ? {cur_addr[DATAWIDTH_BUS-1:2], 2'b00} : '0;
        mdata_d = wr_d ? merged_c : '0;
        ldata_d = ldata_q;
        if (state_q == ST_READ && state_d == ST_DONE) begin
            ldata_d = load_data_c;
        end
    end

    always_ff @(posedge LSU_CLOCK_50) begin
        if (LSU_RESET_InHigh) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ldata_q <= '0;
            maddr_q <= '0;
            mdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ldata_q <= ldata_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
        end
    end

    assign LSU_Busy_Out       = busy_q;
    assign LSU_Done_Out       = done_q;
    assign LSU_Error_Out      = err_q;
    assign LSU_LoadData_Out   = ldata_q;
    assign LSU_MemAddress_Out = maddr_q;
    assign LSU_MemData_Out    = mdata_q;
    assign LSU_MemRD_Out      = rd_q;
    assign LSU_MemWR_Out      = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a byte-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, req, st, sgn;
    logic [1:0]  sz;
    logic [31:0] addr, sdata;
    logic        busy, done, err, rd, wr;
    logic [31:0] ldata, maddr, mdata, mem_rdata;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_ldata;
    int          checks   = 0;
    int          failures = 0;

    always #10 clk = ~clk;

    assign mem_rdata = mem[maddr[7:2]];

    load_store_unit #(.DATAWIDTH_BUS(32)) dut (
        .LSU_CLOCK_50       (clk),
        .LSU_RESET_InHigh   (rst),
        .LSU_Req_In         (req),
        .LSU_Store_In       (st),
        .LSU_Size_In        (sz),
        .LSU_Signed_In      (sgn),
        .LSU_Address_In     (addr),
        .LSU_StoreData_In   (sdata),
        .LSU_Busy_Out       (busy),
        .LSU_Done_Out       (done),
        .LSU_Error_Out      (err),
        .LSU_LoadData_Out   (ldata),
        .LSU_MemAddress_Out (maddr),
        .LSU_MemData_Out    (mdata),
        .LSU_MemRD_Out      (rd),
        .LSU_MemWR_Out      (wr),
        .LSU_MemData_In     (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: memory as four big-endian bytes per word.
    function automatic bit ref_err(input logic [1:0] off, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input bit sg);
        int unsigned b [4];
        int unsigned v;
        int unsigned o;
        o = off;
        for (int i = 0; i < 4; i++) b[i] = (w >> (24 - 8 * i)) & 32'hFF;
        case (size)
            2'd0: begin
                v = b[o];
                if (sg && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                v = b[o] * 256 + b[o + 1];
                if (sg && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] size, input logic [31:0] d);
        int unsigned b [4];
        int unsigned o;
        o = off;
        if (size == 2'd2) return d;
        for (int i = 0; i < 4; i++) b[i] = (w >> (24 - 8 * i)) & 32'hFF;
        if (size == 2'd0) begin
            b[o] = d & 32'hFF;
        end else begin
            b[o]     = (d >> 8) & 32'hFF;
            b[o + 1] = d & 32'hFF;
        end
        return (b[0] << 24) | (b[1] << 16) | (b[2] << 8) | b[3];
    endfunction

    task automatic preload(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    // One request from IDLE to completion, observed once per cycle on the falling edge.
    task automatic run_op(input bit st_i, input logic [1:0] sz_i, input bit sg_i,
                          input logic [31:0] a_i, input logic [31:0] d_i, input string tag);
        int          idx, lat_exp, cyc, rd_cnt, wr_cnt;
        logic [31:0] old_w, wdata;
        bit          e, seen, err_seen, addr_bad, both_bad, busy_bad;
        idx      = int'(a_i[7:2]);
        old_w    = ref_mem[idx];
        e        = ref_err(a_i[1:0], sz_i);
        lat_exp  = e ? 1 : ((st_i && sz_i != 2'd2) ? 3 : 2);
        rd_cnt   = 0;
        wr_cnt   = 0;
        wdata    = '0;
        seen     = 1'b0;
        err_seen = 1'b0;
        addr_bad = 1'b0;
        both_bad = 1'b0;
        busy_bad = 1'b0;
        @(negedge clk);
        req = 1'b1; st = st_i; sz = sz_i; sgn = sg_i; addr = a_i; sdata = d_i;
        @(negedge clk);
        req = 1'b0;
        cyc = 0;
        while (!seen && cyc < 8) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (!busy) busy_bad = 1'b1;
            if (rd && wr) both_bad = 1'b1;
            if ((rd || wr) && maddr !== {a_i[31:2], 2'b00}) addr_bad = 1'b1;
            if (rd) rd_cnt++;
            if (wr) begin
                wr_cnt++;
                wdata = mdata;
                mem[maddr[7:2]] = mdata;
            end
            if (done) begin
                seen     = 1'b1;
                err_seen = err;
            end
        end
        check({tag, ":done"},    32'(seen), 32'd1);
        check({tag, ":latency"}, 32'(cyc), 32'(lat_exp));
        check({tag, ":error"},   32'(err_seen), 32'(e));
        check({tag, ":rd_cnt"},  32'(rd_cnt), (e || (st_i && sz_i == 2'd2)) ? 32'd0 : 32'd1);
        check({tag, ":wr_cnt"},  32'(wr_cnt), (!e && st_i) ? 32'd1 : 32'd0);
        check({tag, ":mem_addr"}, 32'(addr_bad), 32'd0);
        check({tag, ":rd_wr_overlap"}, 32'(both_bad), 32'd0);
        check({tag, ":busy"},    32'(busy_bad), 32'd0);
        if (!e && st_i) begin
            ref_mem[idx] = ref_store(old_w, a_i[1:0], sz_i, d_i);
            check({tag, ":wr_data"}, wdata, ref_mem[idx]);
        end
        if (!e && !st_i) exp_ldata = ref_load(old_w, a_i[1:0], sz_i, sg_i);
        check({tag, ":load_data"}, ldata, exp_ldata);
        @(negedge clk);
        check({tag, ":idle_busy"}, 32'(busy), 32'd0);
        check({tag, ":idle_done"}, 32'(done), 32'd0);
        check({tag, ":mem_word"}, mem[idx], ref_mem[idx]);
    endtask

    initial begin
        bit          wr_seen, done_seen;
        logic [31:0] a;
        logic [1:0]  s;

        rst = 1'b1; req = 1'b0; st = 1'b0; sz = 2'd0; sgn = 1'b0; addr = '0; sdata = '0;
        exp_ldata = '0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:error", 32'(err), 32'd0);
        check("reset:rd_wr", {30'd0, rd, wr}, 32'd0);
        check("reset:load_data", ldata, 32'd0);
        check("reset:mem_addr", maddr, 32'd0);
        check("reset:mem_data", mdata, 32'd0);
        rst = 1'b0;

        preload(4, 32'hDEAD_BEEF);
        run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "word_load");
        check("word_load:value", ldata, 32'hDEAD_BEEF);

        preload(8, 32'h80FF_7F01);
        run_op(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, "byte_s_20");
        check("byte_s_20:value", ldata, 32'hFFFF_FF80);
        run_op(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, "byte_u_23");
        check("byte_u_23:value", ldata, 32'h0000_0001);
        run_op(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "half_s_22");
        check("half_s_22:value", ldata, 32'h0000_7F01);

        preload(12, 32'h1122_3344);
        run_op(1'b1, 2'd0, 1'b0, 32'h31, 32'hFFFF_FFAB, "byte_store_31");
        check("byte_store_31:value", mem[12], 32'h11AB_3344);

        run_op(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, "mis_half_41");
        run_op(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, "mis_word_42");
        run_op(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, "rsvd_40");
        check("rsvd_40:held", ldata, 32'h0000_7F01);

        // Reset in the READ cycle of a byte store.
        @(negedge clk);
        req = 1'b1; st = 1'b1; sz = 2'd0; sgn = 1'b0; addr = 32'h31; sdata = 32'h55;
        @(negedge clk);
        req = 1'b0;
        check("rst_mid:in_read", 32'(rd), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid:busy", 32'(busy), 32'd0);
        check("rst_mid:done", 32'(done), 32'd0);
        check("rst_mid:error", 32'(err), 32'd0);
        check("rst_mid:rd_wr", {30'd0, rd, wr}, 32'd0);
        check("rst_mid:load_data", ldata, 32'd0);
        check("rst_mid:mem_addr", maddr, 32'd0);
        check("rst_mid:mem_data", mdata, 32'd0);
        exp_ldata = '0;
        wr_seen   = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wr) begin
                wr_seen = 1'b1;
                mem[maddr[7:2]] = mdata;
            end
            if (done) done_seen = 1'b1;
        end
        check("rst_mid:no_wr", 32'(wr_seen), 32'd0);
        check("rst_mid:no_done", 32'(done_seen), 32'd0);
        check("rst_mid:mem_word", mem[12], ref_mem[12]);

        // Req held high across two loads; the second is taken in the IDLE cycle after Done.
        @(negedge clk);
        req = 1'b1; st = 1'b0; sz = 2'd2; sgn = 1'b0; addr = 32'h10; sdata = '0;
        @(negedge clk);
        addr = 32'h20;
        check("hold:c1_busy", 32'(busy), 32'd1);
        check("hold:c1_rd", 32'(rd), 32'd1);
        check("hold:c1_addr", maddr, 32'h10);
        @(negedge clk);
        check("hold:c2_busy", 32'(busy), 32'd1);
        check("hold:c2_done", 32'(done), 32'd1);
        check("hold:c2_data", ldata, ref_mem[4]);
        @(negedge clk);
        check("hold:c3_busy", 32'(busy), 32'd0);
        check("hold:c3_done", 32'(done), 32'd0);
        @(negedge clk);
        req = 1'b0;
        check("hold:c4_busy", 32'(busy), 32'd1);
        check("hold:c4_rd", 32'(rd), 32'd1);
        check("hold:c4_addr", maddr, 32'h20);
        @(negedge clk);
        check("hold:c5_done", 32'(done), 32'd1);
        check("hold:c5_data", ldata, ref_mem[8]);
        @(negedge clk);
        check("hold:c6_idle", 32'(busy), 32'd0);
        exp_ldata = ref_mem[8];

        for (int n = 0; n < 80; n++) begin
            s = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end
            run_op(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom,
                   $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
